// File: rtl/mc_ctrl.sv
// Multi-cycle processor control unit: Moore FSM sequencing fetch, decode,
// execute, memory and write-back, with a few input-qualified strobes.
module mc_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_change,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] pc_src,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctrl,
    output logic [3:0] state,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_IF      = 4'd0,
        S_ID      = 4'd1,
        S_MEM_ADR = 4'd2,
        S_MEM_RD  = 4'd3,
        S_WB_MEM  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_EX_R    = 4'd6,
        S_WB_R    = 4'd7,
        S_EX_I    = 4'd8,
        S_WB_I    = 4'd9,
        S_BR      = 4'd10,
        S_JMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    always_comb begin
        state_d    = state_q;
        pc_change  = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        pc_src     = 2'b00;
        alu_src_b  = 2'b00;
        alu_ctrl   = 3'b000;
        illegal    = 1'b0;

        case (state_q)
            S_IF: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_ctrl  = ALU_ADD;
                ir_write  = mem_ready;
                pc_change = mem_ready;
                if (mem_ready) state_d = S_ID;
            end
            S_ID: begin
                alu_src_b = 2'b11;
                alu_ctrl  = ALU_ADD;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEM_ADR;
                    OP_RTYPE:     state_d = S_EX_R;
                    OP_ADDI:      state_d = S_EX_I;
                    OP_BEQ:       state_d = S_BR;
                    OP_J:         state_d = S_JMP;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_IF;
                    end
                endcase
            end
            S_MEM_ADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = ALU_ADD;
                state_d   = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) state_d = S_WB_MEM;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_IF;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) state_d = S_IF;
            end
            S_EX_R: begin
                alu_src_a = 1'b1;
                case (funct)
                    6'b100010: alu_ctrl = ALU_SUB;
                    6'b100100: alu_ctrl = ALU_AND;
                    6'b100101: alu_ctrl = ALU_OR;
                    6'b101010: alu_ctrl = ALU_SLT;
                    default:   alu_ctrl = ALU_ADD;
                endcase
                state_d = S_WB_R;
            end
            S_WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_IF;
            end
            S_EX_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = ALU_ADD;
                state_d   = S_WB_I;
            end
            S_WB_I: begin
                reg_write = 1'b1;
                state_d   = S_IF;
            end
            S_BR: begin
                alu_src_a = 1'b1;
                alu_ctrl  = ALU_SUB;
                pc_src    = 2'b01;
                pc_change = zero;
                state_d   = S_IF;
            end
            S_JMP: begin
                pc_src    = 2'b10;
                pc_change = 1'b1;
                state_d   = S_IF;
            end
            default: state_d = S_IF;
        endcase

        // Reset forces every strobe low combinationally, even though the
        // held state is IF, whose decode would otherwise raise mem_read.
        if (!rst) begin
            pc_change  = 1'b0;
            ir_write   = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            i_or_d     = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = 1'b0;
            pc_src     = 2'b00;
            alu_src_b  = 2'b00;
            alu_ctrl   = 3'b000;
            illegal    = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: the driver queues the expected state and
// strobe vector per cycle, the monitor compares them on the falling edge.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_change, ir_write, mem_read, mem_write, i_or_d;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal;
    logic [1:0] pc_src, alu_src_b;
    logic [2:0] alu_ctrl;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    mc_ctrl dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_change(pc_change), .ir_write(ir_write),
        .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .pc_src(pc_src), .alu_src_b(alu_src_b),
        .alu_ctrl(alu_ctrl), .state(state), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // {pc_change,ir_write,mem_read,mem_write,i_or_d,reg_dst,mem_to_reg,
    //  reg_write,alu_src_a}, pc_src, alu_src_b, alu_ctrl, illegal
    localparam logic [16:0] V_0     = '0;
    localparam logic [16:0] V_IFW   = {9'b001000000, 2'b00, 2'b01, 3'b010, 1'b0};
    localparam logic [16:0] V_IFR   = {9'b111000000, 2'b00, 2'b01, 3'b010, 1'b0};
    localparam logic [16:0] V_ID    = {9'b000000000, 2'b00, 2'b11, 3'b010, 1'b0};
    localparam logic [16:0] V_IDX   = {9'b000000000, 2'b00, 2'b11, 3'b010, 1'b1};
    localparam logic [16:0] V_MADR  = {9'b000000001, 2'b00, 2'b10, 3'b010, 1'b0};
    localparam logic [16:0] V_MRD   = {9'b001010000, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [16:0] V_WBM   = {9'b000000110, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [16:0] V_MWR   = {9'b000110000, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [16:0] V_EXADD = {9'b000000001, 2'b00, 2'b00, 3'b010, 1'b0};
    localparam logic [16:0] V_EXSUB = {9'b000000001, 2'b00, 2'b00, 3'b110, 1'b0};
    localparam logic [16:0] V_EXAND = {9'b000000001, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [16:0] V_EXOR  = {9'b000000001, 2'b00, 2'b00, 3'b001, 1'b0};
    localparam logic [16:0] V_EXSLT = {9'b000000001, 2'b00, 2'b00, 3'b111, 1'b0};
    localparam logic [16:0] V_WBR   = {9'b000001010, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [16:0] V_EXI   = {9'b000000001, 2'b00, 2'b10, 3'b010, 1'b0};
    localparam logic [16:0] V_WBI   = {9'b000000010, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [16:0] V_BRZ   = {9'b100000001, 2'b01, 2'b00, 3'b110, 1'b0};
    localparam logic [16:0] V_BRN   = {9'b000000001, 2'b01, 2'b00, 3'b110, 1'b0};
    localparam logic [16:0] V_JMP   = {9'b100000000, 2'b10, 2'b00, 3'b000, 1'b0};

    typedef struct {
        logic [3:0]  st;
        logic [16:0] vec;
        string       name;
    } exp_t;

    exp_t sb[$];

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [16:0] got;
            e   = sb.pop_front();
            got = {pc_change, ir_write, mem_read, mem_write, i_or_d, reg_dst,
                   mem_to_reg, reg_write, alu_src_a, pc_src, alu_src_b,
                   alu_ctrl, illegal};
            total++;
            if (state !== e.st) begin
                bad++;
                $display("FAIL %s state: got=%0d want=%0d", e.name, state, e.st);
            end
            total++;
            if (got !== e.vec) begin
                bad++;
                $display("FAIL %s outputs: got=%b want=%b", e.name, got, e.vec);
            end
        end
    end

    // One cycle: drive inputs just after the rising edge, queue expectation.
    task automatic cyc(input logic [5:0] o, input logic [5:0] f, input logic z,
                       input logic mr, input logic [3:0] es,
                       input logic [16:0] ev, input string nm);
        op        = o;
        funct     = f;
        zero      = z;
        mem_ready = mr;
        sb.push_back('{es, ev, nm});
        @(posedge clk);
        #1;
    endtask

    task automatic rtype(input logic [5:0] f, input logic [16:0] ex, input string nm);
        cyc(6'h00, f, 1'b0, 1'b1, 4'd0, V_IFR, {nm, "_if"});
        cyc(6'h00, f, 1'b0, 1'b1, 4'd1, V_ID,  {nm, "_id"});
        cyc(6'h00, f, 1'b0, 1'b1, 4'd6, ex,    {nm, "_ex"});
        cyc(6'h00, f, 1'b0, 1'b1, 4'd7, V_WBR, {nm, "_wb"});
    endtask

    initial begin
        rst = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk);
        #1;
        cyc(6'h00, 6'h00, 1'b1, 1'b1, 4'd0, V_0, "reset_hold");
        rst = 1'b1;

        // R-type variants
        rtype(6'b100000, V_EXADD, "add");
        rtype(6'b100010, V_EXSUB, "sub");
        rtype(6'b100100, V_EXAND, "and");
        rtype(6'b100101, V_EXOR,  "or");
        rtype(6'b101010, V_EXSLT, "slt");
        rtype(6'b111111, V_EXADD, "funct_dflt");

        // lw with 2 fetch waits and 3 memory waits: 10 cycles
        cyc(6'b100011, 6'h00, 1'b0, 1'b0, 4'd0, V_IFW,  "lw_if_w1");
        cyc(6'b100011, 6'h00, 1'b0, 1'b0, 4'd0, V_IFW,  "lw_if_w2");
        cyc(6'b100011, 6'h00, 1'b0, 1'b1, 4'd0, V_IFR,  "lw_if");
        cyc(6'b100011, 6'h00, 1'b0, 1'b1, 4'd1, V_ID,   "lw_id");
        cyc(6'b100011, 6'h00, 1'b0, 1'b1, 4'd2, V_MADR, "lw_adr");
        cyc(6'b100011, 6'h00, 1'b0, 1'b0, 4'd3, V_MRD,  "lw_rd_w1");
        cyc(6'b100011, 6'h00, 1'b0, 1'b0, 4'd3, V_MRD,  "lw_rd_w2");
        cyc(6'b100011, 6'h00, 1'b0, 1'b0, 4'd3, V_MRD,  "lw_rd_w3");
        cyc(6'b100011, 6'h00, 1'b0, 1'b1, 4'd3, V_MRD,  "lw_rd");
        cyc(6'b100011, 6'h00, 1'b0, 1'b1, 4'd4, V_WBM,  "lw_wb");

        // beq taken, then not taken
        cyc(6'b000100, 6'h00, 1'b1, 1'b1, 4'd0,  V_IFR, "beq1_if");
        cyc(6'b000100, 6'h00, 1'b1, 1'b1, 4'd1,  V_ID,  "beq1_id");
        cyc(6'b000100, 6'h00, 1'b1, 1'b1, 4'd10, V_BRZ, "beq1_br");
        cyc(6'b000100, 6'h00, 1'b0, 1'b1, 4'd0,  V_IFR, "beq0_if");
        cyc(6'b000100, 6'h00, 1'b0, 1'b1, 4'd1,  V_ID,  "beq0_id");
        cyc(6'b000100, 6'h00, 1'b0, 1'b1, 4'd10, V_BRN, "beq0_br");

        // addi
        cyc(6'b001000, 6'h00, 1'b0, 1'b1, 4'd0, V_IFR, "addi_if");
        cyc(6'b001000, 6'h00, 1'b0, 1'b1, 4'd1, V_ID,  "addi_id");
        cyc(6'b001000, 6'h00, 1'b0, 1'b1, 4'd8, V_EXI, "addi_ex");
        cyc(6'b001000, 6'h00, 1'b0, 1'b1, 4'd9, V_WBI, "addi_wb");

        // illegal opcode: pulse in ID, straight back to IF
        cyc(6'b111111, 6'h00, 1'b0, 1'b1, 4'd0, V_IFR, "ill_if");
        cyc(6'b111111, 6'h00, 1'b0, 1'b1, 4'd1, V_IDX, "ill_id");

        // j then sw back-to-back
        cyc(6'b000010, 6'h00, 1'b0, 1'b1, 4'd0,  V_IFR,  "j_if");
        cyc(6'b000010, 6'h00, 1'b0, 1'b1, 4'd1,  V_ID,   "j_id");
        cyc(6'b000010, 6'h00, 1'b0, 1'b1, 4'd11, V_JMP,  "j_jmp");
        cyc(6'b101011, 6'h00, 1'b0, 1'b1, 4'd0,  V_IFR,  "sw_if");
        cyc(6'b101011, 6'h00, 1'b0, 1'b1, 4'd1,  V_ID,   "sw_id");
        cyc(6'b101011, 6'h00, 1'b0, 1'b1, 4'd2,  V_MADR, "sw_adr");
        cyc(6'b101011, 6'h00, 1'b0, 1'b1, 4'd5,  V_MWR,  "sw_wr");

        // sw stalled in MEM_WR, then asynchronous reset mid-cycle
        cyc(6'b101011, 6'h00, 1'b0, 1'b1, 4'd0, V_IFR,  "swr_if");
        cyc(6'b101011, 6'h00, 1'b0, 1'b1, 4'd1, V_ID,   "swr_id");
        cyc(6'b101011, 6'h00, 1'b0, 1'b1, 4'd2, V_MADR, "swr_adr");
        cyc(6'b101011, 6'h00, 1'b0, 1'b0, 4'd5, V_MWR,  "swr_wait");
        rst = 1'b0;
        cyc(6'b101011, 6'h00, 1'b0, 1'b1, 4'd0, V_0,    "swr_async_rst");
        rst = 1'b1;
        cyc(6'b000000, 6'h00, 1'b0, 1'b0, 4'd0, V_IFW,  "post_rst_if");
        cyc(6'b000000, 6'h00, 1'b0, 1'b1, 4'd0, V_IFR,  "post_rst_if_rdy");
        cyc(6'b000000, 6'h00, 1'b0, 1'b1, 4'd1, V_ID,   "post_rst_id");

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            bad++;
            $display("FAIL drain: got=%0d pending want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
